// File: rtl/config_product_accumulator.sv
// Accumulates signed 8-bit products, or pairs of 4-bit products in two independent lanes, into grouped sums.
// Optional clamping of each addition instead of wrap-around: define CONFIG_ACC_SATURATE_EN.
`timescale 1ns/1ps
module config_product_accumulator #(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           product,
    input  logic                 halvedPrecision,
    input  logic                 inValid,
    input  logic                 inLast,
    output logic                 inReady,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sumHalved,
    output logic                 outValid,
    input  logic                 outReady
`ifdef CONFIG_ACC_SATURATE_EN
    ,
    output logic                 sumSaturated
`endif
);

    localparam int LW = ACC_WIDTH / 2;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t               state;
    logic                 in_group;
    logic                 accept;
    logic                 beat_halved;
    logic [ACC_WIDTH-1:0] full_ext;
    logic [LW-1:0]        upper_ext;
    logic [LW-1:0]        lower_ext;
    logic [ACC_WIDTH-1:0] full_next;
    logic [LW-1:0]        upper_next;
    logic [LW-1:0]        lower_next;
    logic [ACC_WIDTH-1:0] acc_next;

`ifdef CONFIG_ACC_SATURATE_EN
    logic [ACC_WIDTH:0]   full_raw;
    logic [LW:0]          upper_raw;
    logic [LW:0]          lower_raw;
    logic                 full_ovf;
    logic                 upper_ovf;
    logic                 lower_ovf;
    logic                 clamp;
`endif

    // sum doubles as the accumulator; the group's mode is taken from the first beat and held in sumHalved.
    always_comb begin
        accept      = inValid & inReady;
        beat_halved = in_group ? sumHalved : halvedPrecision;
        full_ext    = {{(ACC_WIDTH-8){product[7]}}, product};
        upper_ext   = {{(LW-4){product[7]}}, product[7:4]};
        lower_ext   = {{(LW-4){product[3]}}, product[3:0]};
`ifdef CONFIG_ACC_SATURATE_EN
        full_raw    = {sum[ACC_WIDTH-1], sum} + {full_ext[ACC_WIDTH-1], full_ext};
        upper_raw   = {sum[ACC_WIDTH-1], sum[ACC_WIDTH-1:LW]} + {upper_ext[LW-1], upper_ext};
        lower_raw   = {sum[LW-1], sum[LW-1:0]} + {lower_ext[LW-1], lower_ext};
        full_ovf    = full_raw[ACC_WIDTH] ^ full_raw[ACC_WIDTH-1];
        upper_ovf   = upper_raw[LW] ^ upper_raw[LW-1];
        lower_ovf   = lower_raw[LW] ^ lower_raw[LW-1];
        // An overflowed sum's extra sign bit tells which rail to clamp to.
        full_next   = full_ovf ? {full_raw[ACC_WIDTH], {(ACC_WIDTH-1){~full_raw[ACC_WIDTH]}}}
                               : full_raw[ACC_WIDTH-1:0];
        upper_next  = upper_ovf ? {upper_raw[LW], {(LW-1){~upper_raw[LW]}}} : upper_raw[LW-1:0];
        lower_next  = lower_ovf ? {lower_raw[LW], {(LW-1){~lower_raw[LW]}}} : lower_raw[LW-1:0];
        clamp       = beat_halved ? (upper_ovf | lower_ovf) : full_ovf;
`else
        full_next   = sum + full_ext;
        upper_next  = sum[ACC_WIDTH-1:LW] + upper_ext;
        lower_next  = sum[LW-1:0] + lower_ext;
`endif
        acc_next    = beat_halved ? {upper_next, lower_next} : full_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            sum       <= '0;
            sumHalved <= 1'b0;
            outValid  <= 1'b0;
            inReady   <= 1'b0;
            in_group  <= 1'b0;
`ifdef CONFIG_ACC_SATURATE_EN
            sumSaturated <= 1'b0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    inReady <= 1'b1;
                    if (accept) begin
                        sum <= acc_next;
`ifdef CONFIG_ACC_SATURATE_EN
                        sumSaturated <= sumSaturated | clamp;
`endif
                        if (!in_group) begin
                            in_group  <= 1'b1;
                            sumHalved <= halvedPrecision;
                        end
                        if (inLast) begin
                            state    <= HOLD;
                            inReady  <= 1'b0;
                            outValid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (outReady) begin
                        state    <= ACCUM;
                        inReady  <= 1'b1;
                        outValid <= 1'b0;
                        sum      <= '0;
                        in_group <= 1'b0;
`ifdef CONFIG_ACC_SATURATE_EN
                        sumSaturated <= 1'b0;
`endif
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
